tournament_selector_param: RTL and testbench
============================================

// Module: tournament_selector_param
// PURPOSE
//  Parametrised tournament meta-predictor choosing GShare vs Bimodal per branch.
//  Configurable table depth and counter width, optional global-history index hashing.
//  Registered 1-cycle prediction output. Hardware table-init sweep with a busy flag.
//  Write-first forwarding between same-cycle update and prediction.
//  Sits in the fetch-stage predictor cluster beside the GShare and Bimodal tables.
// PARAMETERS
//  ENTRIES   2048  selector entries; power of 2, >=16; IDX_BITS = $clog2(ENTRIES)
//  CTR_BITS  2     saturating counter width, 2..4; MSB=1 selects GShare
//  INIT_VAL  1     counter value written by init sweep; must be < 2**CTR_BITS
//  GHR_BITS  0     0: index = PC only; >0: index XORed with history (zero-ext/truncated to IDX_BITS)
// PORTS
//  clk                      in   1         clock
//  rst_n                    in   1         synchronous active-low reset
//  predict_valid_i          in   1         prediction request
//  predict_pc_i             in   32        branch PC
//  predict_ghr_i            in   max(GHR_BITS,1)  history snapshot; ignored if GHR_BITS=0
//  gshare_predict_i         in   1         GShare direction, same cycle as request
//  bimodal_predict_i        in   1         Bimodal direction, same cycle as request
//  predict_valid_o          out  1         registered response valid
//  predict_taken_o          out  1         selected direction
//  select_gshare_o          out  1         1 = GShare chosen
//  select_ctr_o             out  CTR_BITS  counter value used for the decision
//  update_valid_i           in   1         resolved-branch training
//  update_pc_i              in   32        resolved PC
//  update_ghr_i             in   max(GHR_BITS,1)  history snapshot captured at predict time
//  update_gshare_correct_i  in   1         GShare was right
//  update_bimodal_correct_i in   1         Bimodal was right
//  init_busy_o              out  1         table sweep in progress
// BEHAVIOUR
//  Index: idx = pc[IDX_BITS+1:2] ^ (GHR_BITS ? ghr_fit : 0). Same function for predict and update.
//  Reset (rst_n=0 at posedge):
//   - predict_valid_o, predict_taken_o, select_gshare_o, select_ctr_o = 0
//   - init_busy_o = 1, state = INIT, init_ptr = 0
//   - Applies mid-sweep or mid-run; the sweep restarts at entry 0.
//  INIT: each cycle writes INIT_VAL to entry init_ptr, then increments init_ptr.
//   - After writing entry ENTRIES-1, go to RUN; init_busy_o drops.
//   - init_busy_o is high for exactly ENTRIES cycles after reset release.
//   - All requests are ignored: predict_valid_o = 0, updates dropped (no queueing).
//  RUN, predict: request at cycle N gives outputs at N+1.
//   - predict_valid_o pulses 1 for one cycle per request.
//   - ctr = table[idx]; select_gshare_o = ctr[CTR_BITS-1]
//   - predict_taken_o = select ? gshare : bimodal; select_ctr_o = ctr
//   - No request: predict_valid_o = 0; other outputs hold their last values.
//  RUN, update: single-cycle read-modify-write at update idx.
//   - {gs_ok, bi_ok} = 10: increment, saturating at 2**CTR_BITS-1
//   - {gs_ok, bi_ok} = 01: decrement, saturating at 0
//   - 00 or 11: no change
//  Forwarding: predict and update at the same idx in the same cycle.
//   - The prediction uses the post-update counter (write-first).
//   - Different idx: the two are independent.
//  Back-to-back updates to the same idx accumulate; each sees the prior cycle's write.
//  Arithmetic: counters are unsigned CTR_BITS wide; saturation prevents wrap. Index XOR wraps modulo ENTRIES.
// TESTING
//  T1 reset/init: release rst_n; count init_busy_o=1 cycles == ENTRIES; predict pc=0x100 before end -> valid_o stays 0; after -> ctr_o=1, select=0, taken=bimodal.
//  T2 training: 3 updates pc=0x200 {10} -> ctr 1->2->3->3 (saturates); predict gs=1, bi=0 -> taken=1, select=1, ctr_o=3.
//  T3 decrement/floor: from ctr=3, 4 updates {01} -> 2,1,0,0; {11} and {00} updates leave 0.
//  T4 forwarding: ctr=1 at pc=0x300; same cycle update {10} + predict pc=0x300 -> next cycle ctr_o=2, select=1.
//  T5 GHR hash (GHR_BITS=8): update pc=0x400, ghr=0x01 {10} twice; predict pc=0x400 ghr=0x00 -> ctr_o=1; ghr=0x01 -> ctr_o=3.
//  T6 mid-run reset: train entries, assert rst_n 1 cycle, release -> busy for ENTRIES cycles, then every probed entry reads INIT_VAL.

Source files
------------

// File: rtl/tournament_selector_param.sv
// Tournament meta-predictor: per-branch saturating counters choose between the
// GShare and Bimodal directions, with a hardware init sweep and write-first forwarding.
module tournament_selector_param #(
  parameter  int ENTRIES  = 2048,
  parameter  int CTR_BITS = 2,
  parameter  int INIT_VAL = 1,
  parameter  int GHR_BITS = 0,
  localparam int IDX_BITS = $clog2(ENTRIES),
  localparam int GHR_W    = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                predict_valid_i,
  input  logic [31:0]         predict_pc_i,
  input  logic [GHR_W-1:0]    predict_ghr_i,
  input  logic                gshare_predict_i,
  input  logic                bimodal_predict_i,
  output logic                predict_valid_o,
  output logic                predict_taken_o,
  output logic                select_gshare_o,
  output logic [CTR_BITS-1:0] select_ctr_o,
  input  logic                update_valid_i,
  input  logic [31:0]         update_pc_i,
  input  logic [GHR_W-1:0]    update_ghr_i,
  input  logic                update_gshare_correct_i,
  input  logic                update_bimodal_correct_i,
  output logic                init_busy_o
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  init_ptr_q, init_ptr_d;
  logic [CTR_BITS-1:0]  tbl [ENTRIES];

  logic [IDX_BITS-1:0]  pred_hash, upd_hash;
  logic [IDX_BITS-1:0]  pred_idx_p0, upd_idx_p0;
  logic                 pred_en_p0, upd_en_p0;
  logic [CTR_BITS-1:0]  upd_next_p0, pred_ctr_p0;
  logic                 wr_en;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [CTR_BITS-1:0]  wr_data;

  logic                 vld_p1, taken_p1, sel_p1;
  logic [CTR_BITS-1:0]  ctr_p1;

  // Counter training: move towards whichever predictor alone was right.
  function automatic logic [CTR_BITS-1:0] ctr_train(input logic [CTR_BITS-1:0] c,
                                                    input logic gs_ok,
                                                    input logic bi_ok);
    logic [CTR_BITS-1:0] r;
    r = c;
    if (gs_ok && !bi_ok && (c != {CTR_BITS{1'b1}}))
      r = c + CTR_BITS'(1);
    else if (!gs_ok && bi_ok && (c != '0))
      r = c - CTR_BITS'(1);
    return r;
  endfunction

  generate
    if (GHR_BITS == 0) begin : g_no_hash
      assign pred_hash = '0;
      assign upd_hash  = '0;
    end else if (GHR_BITS >= IDX_BITS) begin : g_trunc_hash
      assign pred_hash = predict_ghr_i[IDX_BITS-1:0];
      assign upd_hash  = update_ghr_i[IDX_BITS-1:0];
    end else begin : g_ext_hash
      assign pred_hash = {{(IDX_BITS-GHR_BITS){1'b0}}, predict_ghr_i};
      assign upd_hash  = {{(IDX_BITS-GHR_BITS){1'b0}}, update_ghr_i};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == S_INIT) begin
      init_ptr_d = init_ptr_q + IDX_BITS'(1);
      if (init_ptr_q == IDX_BITS'(ENTRIES - 1))
        state_d = S_RUN;
    end
  end

  // Stage p0: index, read-modify-write and same-index forwarding.
  always_comb begin
    pred_idx_p0 = predict_pc_i[IDX_BITS+1:2] ^ pred_hash;
    upd_idx_p0  = update_pc_i[IDX_BITS+1:2] ^ upd_hash;
    pred_en_p0  = (state_q == S_RUN) && predict_valid_i;
    upd_en_p0   = (state_q == S_RUN) && update_valid_i;
    upd_next_p0 = ctr_train(tbl[upd_idx_p0], update_gshare_correct_i, update_bimodal_correct_i);
    pred_ctr_p0 = (upd_en_p0 && (upd_idx_p0 == pred_idx_p0)) ? upd_next_p0 : tbl[pred_idx_p0];
    if (state_q == S_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_ptr_q;
      wr_data = CTR_BITS'(INIT_VAL);
    end else begin
      wr_en   = upd_en_p0;
      wr_idx  = upd_idx_p0;
      wr_data = upd_next_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      tbl[wr_idx] <= wr_data;
  end

  // Stage p1: registered response; payload holds when there is no request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      sel_p1   <= 1'b0;
      ctr_p1   <= '0;
    end else begin
      vld_p1 <= pred_en_p0;
      if (pred_en_p0) begin
        ctr_p1   <= pred_ctr_p0;
        sel_p1   <= pred_ctr_p0[CTR_BITS-1];
        taken_p1 <= pred_ctr_p0[CTR_BITS-1] ? gshare_predict_i : bimodal_predict_i;
      end
    end
  end

  assign predict_valid_o = vld_p1;
  assign predict_taken_o = taken_p1;
  assign select_gshare_o = sel_p1;
  assign select_ctr_o    = ctr_p1;
  assign init_busy_o     = (state_q == S_INIT);

  logic unused_bits;
  assign unused_bits = ^{predict_pc_i[31:IDX_BITS+2], predict_pc_i[1:0],
                         update_pc_i[31:IDX_BITS+2], update_pc_i[1:0],
                         predict_ghr_i, update_ghr_i};

endmodule

// File: tb/tb_tournament_selector_param.sv
// Bench for tournament_selector_param: directed scenarios plus random traffic
// checked against an array-based model of the selector table.
module tb_tournament_selector_param;
  localparam int ENTRIES  = 256;
  localparam int CTR_BITS = 2;
  localparam int INIT_VAL = 1;
  localparam int GHR_BITS = 8;
  localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF = 1 << (CTR_BITS - 1);

  logic                clk;
  logic                rst_n;
  logic                predict_valid_i;
  logic [31:0]         predict_pc_i;
  logic [GHR_BITS-1:0] predict_ghr_i;
  logic                gshare_predict_i;
  logic                bimodal_predict_i;
  logic                predict_valid_o;
  logic                predict_taken_o;
  logic                select_gshare_o;
  logic [CTR_BITS-1:0] select_ctr_o;
  logic                update_valid_i;
  logic [31:0]         update_pc_i;
  logic [GHR_BITS-1:0] update_ghr_i;
  logic                update_gshare_correct_i;
  logic                update_bimodal_correct_i;
  logic                init_busy_o;

  tournament_selector_param #(
    .ENTRIES (ENTRIES),
    .CTR_BITS(CTR_BITS),
    .INIT_VAL(INIT_VAL),
    .GHR_BITS(GHR_BITS)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .predict_valid_i         (predict_valid_i),
    .predict_pc_i            (predict_pc_i),
    .predict_ghr_i           (predict_ghr_i),
    .gshare_predict_i        (gshare_predict_i),
    .bimodal_predict_i       (bimodal_predict_i),
    .predict_valid_o         (predict_valid_o),
    .predict_taken_o         (predict_taken_o),
    .select_gshare_o         (select_gshare_o),
    .select_ctr_o            (select_ctr_o),
    .update_valid_i          (update_valid_i),
    .update_pc_i             (update_pc_i),
    .update_ghr_i            (update_ghr_i),
    .update_gshare_correct_i (update_gshare_correct_i),
    .update_bimodal_correct_i(update_bimodal_correct_i),
    .init_busy_o             (init_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;
  int model_tbl [ENTRIES];
  int e_vld, e_taken, e_sel, e_ctr;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input logic [31:0] pc, input logic [7:0] ghr);
    return int'(((pc >> 2) ^ {24'b0, ghr}) & (ENTRIES - 1));
  endfunction

  task automatic drive_idle();
    predict_valid_i          = 1'b0;
    update_valid_i           = 1'b0;
    predict_pc_i             = '0;
    update_pc_i              = '0;
    predict_ghr_i            = '0;
    update_ghr_i             = '0;
    gshare_predict_i         = 1'b0;
    bimodal_predict_i        = 1'b0;
    update_gshare_correct_i  = 1'b0;
    update_bimodal_correct_i = 1'b0;
  endtask

  // One clock: drive both ports, advance the model (update first), check the response.
  task automatic cycle(input string tag,
                       input bit pv, input logic [31:0] ppc, input logic [7:0] pghr,
                       input bit gs, input bit bi,
                       input bit uv, input logic [31:0] upc, input logic [7:0] ughr,
                       input bit gok, input bit bok);
    int ui, pi;
    predict_valid_i          = pv;
    predict_pc_i             = ppc;
    predict_ghr_i            = pghr;
    gshare_predict_i         = gs;
    bimodal_predict_i        = bi;
    update_valid_i           = uv;
    update_pc_i              = upc;
    update_ghr_i             = ughr;
    update_gshare_correct_i  = gok;
    update_bimodal_correct_i = bok;
    if (uv) begin
      ui = model_idx(upc, ughr);
      if (gok && !bok) model_tbl[ui] = (model_tbl[ui] < CTR_MAX) ? model_tbl[ui] + 1 : CTR_MAX;
      if (!gok && bok) model_tbl[ui] = (model_tbl[ui] > 0) ? model_tbl[ui] - 1 : 0;
    end
    if (pv) begin
      pi      = model_idx(ppc, pghr);
      e_vld   = 1;
      e_ctr   = model_tbl[pi];
      e_sel   = (e_ctr >= CTR_HALF) ? 1 : 0;
      e_taken = e_sel ? int'(gs) : int'(bi);
    end else begin
      e_vld = 0;
    end
    @(posedge clk);
    #1;
    drive_idle();
    check_eq({tag, ".valid"}, int'(predict_valid_o), e_vld);
    check_eq({tag, ".taken"}, int'(predict_taken_o), e_taken);
    check_eq({tag, ".select"}, int'(select_gshare_o), e_sel);
    check_eq({tag, ".ctr"}, int'(select_ctr_o), e_ctr);
  endtask

  task automatic do_reset(input string tag);
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    e_vld = 0; e_taken = 0; e_sel = 0; e_ctr = 0;
    check_eq({tag, ".rst_valid"}, int'(predict_valid_o), 0);
    check_eq({tag, ".rst_taken"}, int'(predict_taken_o), 0);
    check_eq({tag, ".rst_select"}, int'(select_gshare_o), 0);
    check_eq({tag, ".rst_ctr"}, int'(select_ctr_o), 0);
    check_eq({tag, ".rst_busy"}, int'(init_busy_o), 1);
    rst_n = 1'b1;
  endtask

  // Count busy cycles while offering traffic that must be ignored.
  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    while (init_busy_o === 1'b1 && cnt < ENTRIES + 8) begin
      cnt++;
      predict_valid_i          = 1'b1;
      predict_pc_i             = 32'h100;
      update_valid_i           = 1'b1;
      update_pc_i              = 32'h100;
      update_gshare_correct_i  = 1'b1;
      update_bimodal_correct_i = 1'b0;
      @(posedge clk);
      #1;
      check_eq({tag, ".valid_in_init"}, int'(predict_valid_o), 0);
    end
    drive_idle();
    check_eq({tag, ".busy_cycles"}, cnt, ENTRIES);
    for (int i = 0; i < ENTRIES; i++) model_tbl[i] = INIT_VAL;
  endtask

  initial begin
    int exp3 [4];
    logic [31:0] ppc, upc;
    logic [7:0]  pghr, ughr;
    exp3[0] = 2; exp3[1] = 1; exp3[2] = 0; exp3[3] = 0;
    drive_idle();
    rst_n = 1'b0;

    // T1: reset, init sweep, first predictions select bimodal
    do_reset("T1");
    wait_init("T1");
    cycle("T1.p0", 1, 32'h100, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T1.ctr_lit", int'(select_ctr_o), INIT_VAL);
    check_eq("T1.taken_lit", int'(predict_taken_o), 0);
    cycle("T1.p1", 1, 32'h100, 8'h00, 0, 1, 0, 0, 0, 0, 0);
    check_eq("T1.taken_bimodal", int'(predict_taken_o), 1);
    cycle("T1.hold", 0, 32'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

    // T2: training saturates at the top
    for (int k = 0; k < 3; k++)
      cycle("T2.upd", 0, 32'h0, 8'h00, 0, 0, 1, 32'h200, 8'h00, 1, 0);
    cycle("T2.p", 1, 32'h200, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T2.ctr_lit", int'(select_ctr_o), 3);
    check_eq("T2.sel_lit", int'(select_gshare_o), 1);
    check_eq("T2.taken_lit", int'(predict_taken_o), 1);

    // T3: decrement to the floor, observed through forwarding
    for (int k = 0; k < 4; k++) begin
      cycle("T3.dec", 1, 32'h200, 8'h00, 1, 0, 1, 32'h200, 8'h00, 0, 1);
      check_eq("T3.ctr_lit", int'(select_ctr_o), exp3[k]);
    end
    cycle("T3.u11", 0, 32'h0, 8'h00, 0, 0, 1, 32'h200, 8'h00, 1, 1);
    cycle("T3.u00", 0, 32'h0, 8'h00, 0, 0, 1, 32'h200, 8'h00, 0, 0);
    cycle("T3.p", 1, 32'h200, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T3.floor_lit", int'(select_ctr_o), 0);

    // T4: write-first forwarding, and independence of different indices
    cycle("T4.fwd", 1, 32'h300, 8'h00, 1, 0, 1, 32'h300, 8'h00, 1, 0);
    check_eq("T4.ctr_lit", int'(select_ctr_o), 2);
    check_eq("T4.sel_lit", int'(select_gshare_o), 1);
    cycle("T4.indep", 1, 32'h304, 8'h00, 1, 0, 1, 32'h300, 8'h00, 1, 0);
    check_eq("T4.indep_lit", int'(select_ctr_o), INIT_VAL);

    // T5: history hashing selects distinct entries
    cycle("T5.u0", 0, 32'h0, 8'h00, 0, 0, 1, 32'h400, 8'h01, 1, 0);
    cycle("T5.u1", 0, 32'h0, 8'h00, 0, 0, 1, 32'h400, 8'h01, 1, 0);
    cycle("T5.g0", 1, 32'h400, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T5.g0_lit", int'(select_ctr_o), 1);
    cycle("T5.g1", 1, 32'h400, 8'h01, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T5.g1_lit", int'(select_ctr_o), 3);

    // Random traffic over a small PC/history pool to force collisions
    for (int n = 0; n < 400; n++) begin
      ppc  = 32'h1000 + ($urandom_range(0, 7) << 2);
      pghr = 8'($urandom_range(0, 3));
      upc  = 32'h1000 + ($urandom_range(0, 7) << 2);
      ughr = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        upc  = ppc;
        ughr = pghr;
      end
      cycle("RND", 1'($urandom_range(0, 1)), ppc, pghr,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), upc, ughr,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // T6: reset mid-run, then reset again mid-sweep; the table returns to INIT_VAL
    do_reset("T6a");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("T6.busy_mid", int'(init_busy_o), 1);
    do_reset("T6b");
    wait_init("T6");
    cycle("T6.p200", 1, 32'h200, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T6.p200_lit", int'(select_ctr_o), INIT_VAL);
    cycle("T6.p400", 1, 32'h400, 8'h01, 1, 0, 0, 0, 0, 0, 0);
    check_eq("T6.p400_lit", int'(select_ctr_o), INIT_VAL);
    for (int k = 0; k < 16; k++) begin
      ppc  = 32'h1000 + ($urandom_range(0, 7) << 2);
      pghr = 8'($urandom_range(0, 3));
      cycle("T6.probe", 1, ppc, pghr, 1, 0, 0, 0, 0, 0, 0);
      check_eq("T6.probe_lit", int'(select_ctr_o), INIT_VAL);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
